act_sram_reader: RTL and testbench

Streaming read front-end for the 50176-entry × 48-bit activation SRAM. On a start command it issues sequential SRAM reads over a word range and unpacks each 48-bit word into four 12-bit activations. It delivers them one per beat on a valid/ready stream to the downstream PE array. It absorbs the SRAM's one-cycle read latency and downstream backpressure without losing or duplicating data.

---
 rtl/act_sram_pkg.sv | 42 ++++
 rtl/act_word_fifo.sv | 82 ++++++++
 rtl/act_sram_reader.sv | 216 +++++++++++++++++++++
 tb/tb_act_sram_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_sram_pkg.sv
// ---------------------------------------------------------------------------
// act_sram_pkg
// Shared constants, FSM state type and the activation slice helper for the
// activation SRAM streaming reader.
//   ACT_PER_ADDR : activations packed per SRAM word
//   BW_PER_ACT   : bits per activation
//   WORD_W       : SRAM word width
//   ADDR_W       : SRAM address width
//   SRAM_DEPTH   : number of SRAM words
//   FIFO_DEPTH   : word buffer depth (bounds buffered + outstanding reads)
// ---------------------------------------------------------------------------
package act_sram_pkg;

    localparam int ACT_PER_ADDR = 4;
    localparam int BW_PER_ACT   = 12;
    localparam int WORD_W       = ACT_PER_ADDR * BW_PER_ACT;
    localparam int ADDR_W       = 16;
    localparam int SRAM_DEPTH   = 50176;
    localparam int FIFO_DEPTH   = 2;

    localparam int BEAT_W = $clog2(ACT_PER_ADDR);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    // Index of the final activation inside a word.
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(ACT_PER_ADDR - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    // Slice 0 is the most significant activation, so a word streams out
    // MSB-first: [47:36], [35:24], [23:12], [11:0].
    function automatic logic [BW_PER_ACT-1:0] act_slice(
        input logic [WORD_W-1:0] word,
        input logic [BEAT_W-1:0] idx
    );
        return word[(ACT_PER_ADDR - 1 - int'(idx)) * BW_PER_ACT +: BW_PER_ACT];
    endfunction

endpackage

// File: rtl/act_word_fifo.sv
// ---------------------------------------------------------------------------
// act_word_fifo
// Small synchronous FIFO holding whole SRAM words between the read port and
// the activation unpacker.
//   clk, rst    : clock, asynchronous active-high reset
//   push, push_data : write one word (ignored when full and not popping)
//   pop         : discard the head word (ignored when empty)
//   head        : oldest word
//   second      : word behind the head (valid when count >= 2); lets the
//                 unpacker switch words without a bubble
//   count, full, empty : occupancy
// ---------------------------------------------------------------------------
module act_word_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 48,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] second,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head   = mem[rd_ptr_reg];
    assign second = mem[ptr_inc(rd_ptr_reg)];

endmodule

// File: rtl/act_sram_reader.sv
// ---------------------------------------------------------------------------
// act_sram_reader
// Streams a range of activation SRAM words out as 12-bit activations, one per
// valid/ready beat, four per word, most significant slice first.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : command strobe, sampled only while idle
//   base_addr          : first word address (captured on start)
//   num_words          : number of words to stream (captured on start)
//   busy, done         : transfer in progress / one-cycle completion pulse
//   sram_csb           : active-low read enable, low only when a read issues
//   sram_raddr         : read address
//   sram_rdata         : read data, valid the cycle after the read
//   out_valid/out_ready/out_data/out_last : activation stream
// ---------------------------------------------------------------------------
module act_sram_reader
    import act_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     num_words,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_csb,
    output logic [ADDR_W-1:0]     sram_raddr,
    input  logic [WORD_W-1:0]     sram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BW_PER_ACT-1:0] out_data,
    output logic                  out_last
);

    localparam int CW1 = CNT_W + 1;

    state_t                state_reg;
    state_t                state_next;
    logic [ADDR_W-1:0]     ptr_reg;
    logic [ADDR_W-1:0]     ptr_next;
    logic [ADDR_W-1:0]     remaining_reg;
    logic [ADDR_W-1:0]     remaining_next;
    logic [ADDR_W-1:0]     words_left_reg;
    logic [ADDR_W-1:0]     words_left_next;
    logic                  inflight_reg;
    logic                  done_reg;
    logic                  done_next;
    logic                  out_valid_reg;
    logic                  out_valid_next;
    logic                  out_last_reg;
    logic                  out_last_next;
    logic [BW_PER_ACT-1:0] out_data_reg;
    logic [BW_PER_ACT-1:0] out_data_next;
    logic [BEAT_W-1:0]     beat_reg;
    logic [BEAT_W-1:0]     beat_next;
    logic [BEAT_W-1:0]     beat_inc;

    logic                  issue;
    logic                  xfer_start;
    logic                  handshake;
    logic                  word_pop;
    logic                  credit_ok;
    logic                  second_avail;

    logic [WORD_W-1:0]     fifo_head;
    logic [WORD_W-1:0]     fifo_second;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Every word in the FIFO or in flight from the SRAM holds a credit.
    // The word currently being unpacked is still the FIFO head, so the
    // output register never needs its own credit. Credits are taken before
    // the pop of this cycle is applied.
    assign credit_ok    = ({1'b0, fifo_count} + CW1'(inflight_reg)) < CW1'(FIFO_DEPTH);
    assign second_avail = (fifo_count >= CNT_W'(2));
    assign handshake    = out_valid_reg & out_ready;
    assign word_pop     = handshake && (beat_reg == LAST_BEAT);
    assign beat_inc     = beat_reg + 1'b1;

    act_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_word_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (sram_rdata),
        .pop       (word_pop),
        .head      (fifo_head),
        .second    (fifo_second),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Read sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        issue          = 1'b0;
        xfer_start     = 1'b0;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    xfer_start     = 1'b1;
                    ptr_next       = base_addr;
                    remaining_next = num_words;
                    state_next     = (num_words == '0) ? ST_DRAIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if ((remaining_reg != '0) && credit_ok && !fifo_full) begin
                    issue          = 1'b1;
                    ptr_next       = ptr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == ADDR_W'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // words_left is zero here only for an empty transfer.
                if ((words_left_reg == '0) || (handshake && out_last_reg)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Unpacker: the output register shows slice beat_reg of the FIFO head.
    // When it is empty, the FIFO is empty too, so the first slice of an
    // arriving word is taken straight from sram_rdata while the word itself
    // is pushed into the FIFO in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        out_last_next   = out_last_reg;
        beat_next       = beat_reg;
        words_left_next = words_left_reg;

        if (xfer_start) begin
            words_left_next = num_words;
        end else if (word_pop) begin
            words_left_next = words_left_reg - 1'b1;
        end

        if (handshake && (beat_reg != LAST_BEAT) && !fifo_empty) begin
            beat_next     = beat_inc;
            out_data_next = act_slice(fifo_head, beat_inc);
            out_last_next = (beat_inc == LAST_BEAT) && (words_left_reg == ADDR_W'(1));
        end else if (word_pop) begin
            beat_next     = '0;
            out_last_next = 1'b0;
            if (second_avail) begin
                out_valid_next = 1'b1;
                out_data_next  = act_slice(fifo_second, '0);
            end else if (inflight_reg) begin
                out_valid_next = 1'b1;
                out_data_next  = act_slice(sram_rdata, '0);
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (!out_valid_reg && inflight_reg) begin
            out_valid_next = 1'b1;
            out_data_next  = act_slice(sram_rdata, '0);
            out_last_next  = 1'b0;
            beat_next      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            remaining_reg  <= '0;
            words_left_reg <= '0;
            inflight_reg   <= 1'b0;
            done_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            beat_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            remaining_reg  <= remaining_next;
            words_left_reg <= words_left_next;
            inflight_reg   <= issue;
            done_reg       <= done_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            beat_reg       <= beat_next;
        end
    end

    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign sram_csb   = ~issue;
    assign sram_raddr = ptr_reg;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_last   = out_last_reg;

endmodule

// File: tb/tb_act_sram_reader.sv
// ---------------------------------------------------------------------------
// tb_act_sram_reader
// Directed bench for act_sram_reader with a behavioural one-cycle-latency
// SRAM. Outputs are sampled on the falling clock edge; inputs for the same
// cycle are applied right after sampling.
// ---------------------------------------------------------------------------
module tb_act_sram_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic        sram_csb;
    logic [15:0] sram_raddr;
    logic [47:0] sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;

    logic [47:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] data_q [$];
    logic [11:0] exp_q  [$];
    logic [15:0] addr_q [$];
    int issued, valid_cnt, done_cyc, last_cyc, last_idx, first_valid_cyc;
    int max_out, busy_err, stable_err, stall_reads;

    act_sram_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .sram_csb   (sram_csb),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    // One-cycle read latency SRAM model.
    always @(posedge clk) begin
        if (!sram_csb) begin
            sram_rdata <= mem[sram_raddr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        logic [63:0] g;
        check({tag, " beat count"}, data_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < data_q.size()) ? 64'(data_q[i]) : 64'hDEAD_BEEF;
            check($sformatf("%s beat%0d", tag, i), g, exp_q[i]);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            1:       return (k % 2) == 1;
            2:       return !(k >= 5 && k < 25);
            default: return 1'b1;
        endcase
    endfunction

    // Runs one transfer from the start strobe (cycle 0) until done or a
    // cycle budget expires, collecting the stream and protocol statistics.
    task automatic run_xfer(input logic [15:0] b, input logic [15:0] n,
                            input int mode, input int restart_at);
        int k = 0;
        int hs_cnt = 0;
        int popped = 0;
        logic stall_prev = 1'b0;
        logic [11:0] prev_data = '0;
        logic prev_last = 1'b0;
        data_q.delete();
        addr_q.delete();
        issued = 0; valid_cnt = 0; done_cyc = -1; last_cyc = -1; last_idx = -1;
        first_valid_cyc = -1; max_out = 0; busy_err = 0; stable_err = 0; stall_reads = 0;

        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        out_ready = ready_for(mode, 0);
        while (k < 400 && done_cyc < 0) begin
            @(negedge clk);
            k++;
            start = (k == restart_at);
            if (k == restart_at) begin
                base_addr = 16'h0200;
                num_words = 16'd7;
            end
            out_ready = ready_for(mode, k);

            if (!sram_csb) begin
                addr_q.push_back(sram_raddr);
                issued++;
                if (mode == 2 && k >= 5 && k < 25) stall_reads++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (stall_prev && !(out_valid && out_data == prev_data && out_last == prev_last))
                stable_err++;
            if (out_valid) begin
                valid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = k;
            end
            if (out_valid && out_ready) begin
                data_q.push_back(out_data);
                hs_cnt++;
                if (hs_cnt % 4 == 0) popped++;
                if (out_last) begin
                    last_cyc = k;
                    last_idx = hs_cnt;
                end
            end
            if (done) begin
                done_cyc = k;
                if (busy) busy_err++;
            end else if (!busy) begin
                busy_err++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        $display("xfer base=%h num=%0d: %0d beats, %0d reads, done at cycle %0d",
                 b, n, data_q.size(), issued, done_cyc);
        @(negedge clk);
        check("done is one cycle", done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = {16'(i), ~16'(i), 16'(i) ^ 16'h5A5A};
        end
        mem[0]        = 48'hABC123456789;
        mem[5]        = 48'hFEDCBA987654;
        mem[10]       = 48'h111222333444;
        mem[11]       = 48'h555666777888;
        mem[12]       = 48'h999AAABBBCCC;
        mem[20]       = 48'h123456789ABC;
        mem[21]       = 48'hDEF012345678;
        mem[22]       = 48'h9ABCDEF01234;
        mem[16'hFFFF] = 48'h777888999AAA;

        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst csb", sram_csb, 1'b1);
        check("rst raddr", sram_raddr, 16'h0000);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data", out_data, 12'h000);
        check("rst out_last", out_last, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // T1: single word, ready always high.
        run_xfer(16'd0, 16'd1, 0, 0);
        exp_q = '{12'hABC, 12'h123, 12'h456, 12'h789};
        check_stream("T1");
        check("T1 first valid cycle", first_valid_cyc, 3);
        check("T1 last cycle", last_cyc, 6);
        check("T1 last beat index", last_idx, 4);
        check("T1 done cycle", done_cyc, 7);
        check("T1 reads", issued, 1);
        check("T1 read addr", addr_q.size() > 0 ? addr_q[0] : 16'hBAD0, 16'h0000);
        check("T1 busy window", busy_err, 0);

        // T2: three words, ready toggling.
        run_xfer(16'd10, 16'd3, 1, 0);
        exp_q = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555, 12'h666,
                  12'h777, 12'h888, 12'h999, 12'hAAA, 12'hBBB, 12'hCCC};
        check_stream("T2");
        check("T2 reads", issued, 3);
        check("T2 addr0", addr_q.size() > 0 ? addr_q[0] : 16'hBAD0, 16'd10);
        check("T2 addr2", addr_q.size() > 2 ? addr_q[2] : 16'hBAD0, 16'd12);
        check("T2 last beat index", last_idx, 12);
        check("T2 max outstanding", max_out, 2);
        check("T2 held data", stable_err, 0);
        check("T2 busy window", busy_err, 0);

        // T3: empty transfer.
        run_xfer(16'd7, 16'd0, 0, 0);
        check("T3 done cycle", done_cyc, 2);
        check("T3 reads", issued, 0);
        check("T3 valid cycles", valid_cnt, 0);
        check("T3 busy window", busy_err, 0);

        // T4: 20-cycle stall mid-transfer.
        run_xfer(16'd20, 16'd3, 2, 0);
        exp_q = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h012,
                  12'h345, 12'h678, 12'h9AB, 12'hCDE, 12'hF01, 12'h234};
        check_stream("T4");
        check("T4 held data", stable_err, 0);
        check("T4 max outstanding", max_out, 2);
        check("T4 reads during stall", stall_reads, 0);
        check("T4 reads", issued, 3);

        // T5: reset while a read is in flight, then a clean transfer.
        @(negedge clk);
        start = 1'b1; base_addr = 16'd30; num_words = 16'd4;
        @(negedge clk);
        start = 1'b0;
        check("T5 read issued", sram_csb, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("T5 rst busy", busy, 1'b0);
        check("T5 rst csb", sram_csb, 1'b1);
        check("T5 rst raddr", sram_raddr, 16'h0000);
        check("T5 rst out_valid", out_valid, 1'b0);
        check("T5 rst out_data", out_data, 12'h000);
        @(negedge clk);
        check("T5 stale data dropped", out_valid, 1'b0);
        rst = 1'b0;
        run_xfer(16'd5, 16'd1, 0, 0);
        exp_q = '{12'hFED, 12'hCBA, 12'h987, 12'h654};
        check_stream("T5");
        check("T5 done cycle", done_cyc, 7);

        // T6: address wrap with an ignored second start.
        run_xfer(16'hFFFF, 16'd2, 0, 4);
        exp_q = '{12'h777, 12'h888, 12'h999, 12'hAAA,
                  12'hABC, 12'h123, 12'h456, 12'h789};
        check_stream("T6");
        check("T6 reads", issued, 2);
        check("T6 addr0", addr_q.size() > 0 ? addr_q[0] : 16'hBAD0, 16'hFFFF);
        check("T6 addr1", addr_q.size() > 1 ? addr_q[1] : 16'hBAD0, 16'h0000);
        check("T6 done cycle", done_cyc, 11);
        repeat (3) @(negedge clk);
        check("T6 restart ignored", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
